// File: rtl/hist_pkg.sv
// Shared types and sizing helpers for the histogram contrast stretcher.
package hist_pkg;

    // Coefficient-computation sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_STORE,
        ST_DONE
    } div_state_e;

    // Per-pixel output selection carried down the pixel pipeline
    typedef enum logic [1:0] {
        PM_ZERO,
        PM_FULL,
        PM_PASS,
        PM_MUL
    } pix_mode_e;

    localparam int FRAC_DEFAULT = 8;

    // Full-scale code for a DW-bit channel
    function automatic int fs(input int dw);
        return (1 << dw) - 1;
    endfunction

    // Width of the fixed-point scale coefficient
    function automatic int qw(input int dw, input int frac);
        return dw + frac;
    endfunction

endpackage

// File: rtl/stretch_div.sv
// Restoring divider, one quotient bit per cycle, QW cycles per division.
// The first iteration runs on the start cycle itself, so done pulses
// QW-1 cycles after start is accepted; the quotient holds until the next start.
module stretch_div #(
    parameter int DW = 8,
    parameter int QW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [QW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [QW-1:0] quot_o
);
    localparam int CW = $clog2(QW + 1);

    logic          busy_q, done_q, accept, take;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] rem_q, dvs_q, rem_d, rem_src, dvs_src;
    logic [QW-1:0] dvd_q, dvd_src, dvd_d;
    logic [DW:0]   trial;

    assign accept = start_i && !busy_q;

    // One restoring step; on accept the step works on the fresh operands
    always_comb begin
        rem_src = accept ? '0 : rem_q;
        dvd_src = accept ? dividend_i : dvd_q;
        dvs_src = accept ? divisor_i : dvs_q;
        trial   = {rem_src, dvd_src[QW-1]};
        take    = (trial >= {1'b0, dvs_src});
        rem_d   = DW'(take ? trial - {1'b0, dvs_src} : trial);
        dvd_d   = {dvd_src[QW-2:0], take};
    end

    // Iteration counter, partial remainder and shifting dividend/quotient
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept || busy_q) begin
                rem_q <= rem_d;
                dvd_q <= dvd_d;
                dvs_q <= dvs_src;
            end
            if (accept) begin
                busy_q <= 1'b1;
                cnt_q  <= CW'(1);
            end else if (busy_q) begin
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(QW - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quot_o = dvd_q;

endmodule

// File: rtl/hist_stretch_pipe.sv
// Per-frame contrast stretcher: gathers min/max over frame N, computes a
// scale per channel during blanking, applies it to frame N+1 in 3 stages.
module hist_stretch_pipe import hist_pkg::*; #(
    parameter int DW   = 8,
    parameter int CH   = 3,
    parameter int FRAC = FRAC_DEFAULT
) (
    input  logic             pixelclk,
    input  logic             reset,
    input  logic [CH*DW-1:0] din,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_de,
    input  logic             en,
    output logic [CH*DW-1:0] dout,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [CH*DW-1:0] o_min,
    output logic [CH*DW-1:0] o_max,
    output logic             o_stale
);
    localparam int FSV = fs(DW);
    localparam int QW  = qw(DW, FRAC);
    localparam int PW  = DW + QW;
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [DW-1:0] FS_V      = DW'(FSV);
    localparam logic [QW-1:0] ONE_SCALE = QW'(1) << FRAC;
    localparam logic [QW-1:0] DIVIDEND  = QW'(FSV) << FRAC;
    localparam logic [PW-1:0] HALF      = PW'(1) << (FRAC - 1);

    logic vs_q, rise, fall;
    logic seen_q, seen_d;
    logic [CH-1:0][DW-1:0] acc_min_q, acc_max_q, acc_min_d, acc_max_d;
    logic [CH-1:0][DW-1:0] stg_min_q, stg_max_q, app_min_q, app_max_q;
    logic [CH-1:0][QW-1:0] pend_scale_q, app_scale_q;
    logic [CH-1:0]         pend_flat_q, app_flat_q;
    logic                  pend_vld_q, stale_q;
    div_state_e            state_q;
    logic [CHW-1:0]        ch_q;
    logic [DW-1:0]         ch_range;
    logic                  div_start, div_busy, div_done;
    logic [QW-1:0]         div_quot;
    logic [2:0][2:0]       sync_q;

    assign rise = i_vsync && !vs_q;
    assign fall = !i_vsync && vs_q;

    // Running min/max over active pixels, restarted at frame start
    always_comb begin
        acc_min_d = acc_min_q;
        acc_max_d = acc_max_q;
        seen_d    = seen_q;
        if (rise) begin
            acc_min_d = {CH{FS_V}};
            acc_max_d = '0;
            seen_d    = 1'b0;
        end
        if (i_vsync && i_de) begin
            seen_d = 1'b1;
            for (int c = 0; c < CH; c++) begin
                if (din[c*DW +: DW] < acc_min_d[c]) acc_min_d[c] = din[c*DW +: DW];
                if (din[c*DW +: DW] > acc_max_d[c]) acc_max_d[c] = din[c*DW +: DW];
            end
        end
    end

    // Statistics registers and vsync edge history
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            vs_q      <= 1'b0;
            seen_q    <= 1'b0;
            acc_min_q <= {CH{FS_V}};
            acc_max_q <= '0;
        end else begin
            vs_q      <= i_vsync;
            seen_q    <= seen_d;
            acc_min_q <= acc_min_d;
            acc_max_q <= acc_max_d;
        end
    end

    assign ch_range  = stg_max_q[ch_q] - stg_min_q[ch_q];
    assign div_start = (state_q == ST_LOAD) && (ch_range != '0) && !div_busy;

    stretch_div #(
        .DW (DW),
        .QW (QW)
    ) u_div (
        .clk        (pixelclk),
        .reset      (reset),
        .start_i    (div_start),
        .dividend_i (DIVIDEND),
        .divisor_i  (ch_range),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (div_quot)
    );

    // Coefficient sequencer plus frame-start swap of pending into applied set;
    // the swap is only legal with the sequencer idle so a half-written
    // pending set can never reach the pixel path
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            stg_min_q    <= '0;
            stg_max_q    <= '0;
            pend_scale_q <= '0;
            pend_flat_q  <= '0;
            pend_vld_q   <= 1'b0;
            app_min_q    <= '0;
            app_max_q    <= {CH{FS_V}};
            app_scale_q  <= {CH{ONE_SCALE}};
            app_flat_q   <= '0;
            stale_q      <= 1'b0;
        end else begin
            stale_q <= 1'b0;
            if (rise) begin
                if (state_q != ST_IDLE) begin
                    stale_q <= 1'b1;
                end else if (pend_vld_q) begin
                    app_min_q   <= stg_min_q;
                    app_max_q   <= stg_max_q;
                    app_scale_q <= pend_scale_q;
                    app_flat_q  <= pend_flat_q;
                    pend_vld_q  <= 1'b0;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (fall && seen_q) begin
                        stg_min_q <= acc_min_q;
                        stg_max_q <= acc_max_q;
                        ch_q      <= '0;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (ch_range == '0) begin
                        pend_flat_q[ch_q] <= 1'b1;
                        state_q           <= ST_STORE;
                    end else if (!div_busy) begin
                        pend_flat_q[ch_q] <= 1'b0;
                        state_q           <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (div_done) state_q <= ST_STORE;
                end
                ST_STORE: begin
                    if (!pend_flat_q[ch_q]) pend_scale_q[ch_q] <= div_quot;
                    if (ch_q == CHW'(CH - 1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        ch_q    <= ch_q + CHW'(1);
                        state_q <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    pend_vld_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [DW-1:0]   pix, s1_val_q, s2_val_q, s3_q;
        pix_mode_e       s1_mode_q, s2_mode_q;
        logic [PW-1:0]   s2_prod_q;
        logic [PW:0]     rnd;
        logic [PW-FRAC:0] q_full;

        assign pix    = din[c*DW +: DW];
        assign rnd    = {1'b0, s2_prod_q} + {1'b0, HALF};
        assign q_full = (PW-FRAC+1)'(rnd >> FRAC);

        // S1: clamp against the applied window, or select bypass/blank
        always_ff @(posedge pixelclk) begin
            if (reset) begin
                s1_mode_q <= PM_ZERO;
                s1_val_q  <= '0;
            end else begin
                s1_val_q <= '0;
                if (!i_de) begin
                    s1_mode_q <= PM_ZERO;
                end else if (!en || app_flat_q[c]) begin
                    s1_mode_q <= PM_PASS;
                    s1_val_q  <= pix;
                end else if (pix <= app_min_q[c]) begin
                    s1_mode_q <= PM_ZERO;
                end else if (pix >= app_max_q[c]) begin
                    s1_mode_q <= PM_FULL;
                end else begin
                    s1_mode_q <= PM_MUL;
                    s1_val_q  <= pix - app_min_q[c];
                end
            end
        end

        // S2: offset times fixed-point scale
        always_ff @(posedge pixelclk) begin
            if (reset) begin
                s2_mode_q <= PM_ZERO;
                s2_val_q  <= '0;
                s2_prod_q <= '0;
            end else begin
                s2_mode_q <= s1_mode_q;
                s2_val_q  <= s1_val_q;
                s2_prod_q <= PW'(s1_val_q) * PW'(app_scale_q[c]);
            end
        end

        // S3: round to nearest, saturate to full scale
        always_ff @(posedge pixelclk) begin
            if (reset) begin
                s3_q <= '0;
            end else begin
                case (s2_mode_q)
                    PM_ZERO: s3_q <= '0;
                    PM_FULL: s3_q <= FS_V;
                    PM_PASS: s3_q <= s2_val_q;
                    default: s3_q <= (q_full > (PW-FRAC+1)'(FSV)) ? FS_V : q_full[DW-1:0];
                endcase
            end
        end

        assign dout[c*DW +: DW] = s3_q;
    end

    // Sync delay line matched to the 3-stage pixel path
    always_ff @(posedge pixelclk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[1:0], {i_hsync, i_vsync, i_de}};
    end

    assign {o_hsync, o_vsync, o_de} = sync_q[2];
    assign o_min   = app_min_q;
    assign o_max   = app_max_q;
    assign o_stale = stale_q;

endmodule

// File: tb/tb_hist_stretch_pipe.sv
// Directed bench for hist_stretch_pipe at default parameters (DW=8, CH=3, FRAC=8).
module tb_hist_stretch_pipe;
    localparam int DW = 8;
    localparam int CH = 3;
    localparam int W  = CH * DW;

    logic         pixelclk = 1'b0;
    logic         reset, i_hsync, i_vsync, i_de, en;
    logic [W-1:0] din, dout, o_min, o_max;
    logic         o_hsync, o_vsync, o_de, o_stale;
    int           checks = 0;
    int           failures = 0;

    always #5 pixelclk = ~pixelclk;

    hist_stretch_pipe #(.DW(DW), .CH(CH), .FRAC(8)) dut (
        .pixelclk (pixelclk),
        .reset    (reset),
        .din      (din),
        .i_hsync  (i_hsync),
        .i_vsync  (i_vsync),
        .i_de     (i_de),
        .en       (en),
        .dout     (dout),
        .o_hsync  (o_hsync),
        .o_vsync  (o_vsync),
        .o_de     (o_de),
        .o_min    (o_min),
        .o_max    (o_max),
        .o_stale  (o_stale)
    );

    task automatic tick();
        @(posedge pixelclk);
        #1;
    endtask

    // Hold one active pixel for 3 cycles so dout then shows its result
    task automatic drive(input logic [W-1:0] d);
        din = d; i_de = 1'b1; i_vsync = 1'b1; i_hsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_end(input int blank);
        i_de = 1'b0; din = '0; i_vsync = 1'b0;
        repeat (blank) tick();
    endtask

    task automatic frame_start(output int st);
        st = 0; i_vsync = 1'b1; i_de = 1'b0; din = '0;
        repeat (4) begin
            tick();
            st += int'(o_stale);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; din = '0; i_hsync = 0; i_vsync = 0; i_de = 0; en = 1'b1;
        repeat (3) tick();
        checks++; if (dout !== '0) begin failures++; $display("FAIL reset_dout got=%h want=0", dout); end
        checks++; if (o_min !== '0) begin failures++; $display("FAIL reset_min got=%h want=0", o_min); end
        checks++; if (o_max !== {3{8'hFF}}) begin failures++; $display("FAIL reset_max got=%h want=ffffff", o_max); end
        checks++; if ({o_hsync, o_vsync, o_de, o_stale} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b want=0000", {o_hsync, o_vsync, o_de, o_stale}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_identity();
        int st;
        logic [7:0] a;
        logic [W-1:0] v;
        frame_start(st);
        checks++; if (st != 0) begin failures++; $display("FAIL ident_stale got=%0d want=0", st); end
        checks++; if (o_min !== '0 || o_max !== {3{8'hFF}}) begin failures++; $display("FAIL ident_coef min=%h max=%h want 0/ffffff", o_min, o_max); end
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            v = {a ^ 8'h5A, 8'hFF - a, a};
            drive(v);
            checks++; if (dout !== v) begin failures++; $display("FAIL ident_ramp i=%0d got=%h want=%h", i, dout, v); end
        end
        frame_end(80);
    endtask

    task automatic test_stretch();
        int st;
        logic [7:0] p1 [4] = '{8'd50, 8'd100, 8'd150, 8'd75};
        logic [7:0] p2 [5] = '{8'd50, 8'd100, 8'd150, 8'd40, 8'd200};
        logic [7:0] e2 [5] = '{8'd0, 8'd127, 8'd255, 8'd0, 8'd255};
        frame_start(st);
        checks++; if (o_min !== '0 || o_max !== {3{8'hFF}}) begin failures++; $display("FAIL stretch_coef1 min=%h max=%h want 0/ffffff", o_min, o_max); end
        for (int i = 0; i < 4; i++) begin
            drive({3{p1[i]}});
            checks++; if (dout !== {3{p1[i]}}) begin failures++; $display("FAIL stretch_f1 pix=%0d got=%h want=%h", p1[i], dout, {3{p1[i]}}); end
        end
        frame_end(80);
        frame_start(st);
        checks++; if (st != 0) begin failures++; $display("FAIL stretch_stale got=%0d want=0", st); end
        checks++; if (o_min !== {3{8'd50}} || o_max !== {3{8'd150}}) begin failures++; $display("FAIL stretch_coef2 min=%h max=%h want 323232/969696", o_min, o_max); end
        for (int i = 0; i < 5; i++) begin
            drive({3{p2[i]}});
            checks++; if (dout !== {3{e2[i]}}) begin failures++; $display("FAIL stretch_f2 pix=%0d got=%h want=%h", p2[i], dout, {3{e2[i]}}); end
        end
        frame_end(80);
    endtask

    task automatic test_flat();
        int st;
        frame_start(st);
        checks++; if (o_min !== {3{8'd40}} || o_max !== {3{8'd200}}) begin failures++; $display("FAIL flat_coefC min=%h max=%h want 282828/c8c8c8", o_min, o_max); end
        drive({3{8'd77}});
        checks++; if (dout !== {3{8'd59}}) begin failures++; $display("FAIL flat_frameC got=%h want=3b3b3b", dout); end
        frame_end(20);
        frame_start(st);
        checks++; if (st != 0) begin failures++; $display("FAIL flat_stale got=%0d want=0", st); end
        checks++; if (o_min !== {3{8'd77}} || o_max !== {3{8'd77}}) begin failures++; $display("FAIL flat_coefD min=%h max=%h want 4d4d4d/4d4d4d", o_min, o_max); end
        drive({3{8'd77}});
        checks++; if (dout !== {3{8'd77}}) begin failures++; $display("FAIL flat_77 got=%h want=4d4d4d", dout); end
        drive({3{8'd90}});
        checks++; if (dout !== {3{8'd90}}) begin failures++; $display("FAIL flat_90 got=%h want=5a5a5a", dout); end
    endtask

    task automatic test_stale();
        int st;
        logic [7:0] p [5] = '{8'd80, 8'd85, 8'd77, 8'd90, 8'd83};
        logic [7:0] e [5] = '{8'd59, 8'd157, 8'd0, 8'd255, 8'd118};
        frame_end(20);
        frame_start(st);
        checks++; if (st != 1) begin failures++; $display("FAIL stale_pulse got=%0d want=1", st); end
        checks++; if (o_min !== {3{8'd77}} || o_max !== {3{8'd77}}) begin failures++; $display("FAIL stale_keep min=%h max=%h want 4d4d4d/4d4d4d", o_min, o_max); end
        drive({3{8'd77}});
        checks++; if (dout !== {3{8'd77}}) begin failures++; $display("FAIL stale_77 got=%h want=4d4d4d", dout); end
        drive({3{8'd90}});
        checks++; if (dout !== {3{8'd90}}) begin failures++; $display("FAIL stale_90 got=%h want=5a5a5a", dout); end
        frame_end(80);
        frame_start(st);
        checks++; if (st != 0) begin failures++; $display("FAIL stale_next got=%0d want=0", st); end
        checks++; if (o_min !== {3{8'd77}} || o_max !== {3{8'd90}}) begin failures++; $display("FAIL stale_coef min=%h max=%h want 4d4d4d/5a5a5a", o_min, o_max); end
        for (int i = 0; i < 5; i++) begin
            drive({3{p[i]}});
            checks++; if (dout !== {3{e[i]}}) begin failures++; $display("FAIL stale_map pix=%0d got=%h want=%h", p[i], dout, {3{e[i]}}); end
        end
    endtask

    task automatic test_reset_mid_div();
        int st;
        logic [7:0] p [3] = '{8'd50, 8'd100, 8'd150};
        frame_end(28);
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (o_min !== '0 || o_max !== {3{8'hFF}}) begin failures++; $display("FAIL mid_coef min=%h max=%h want 0/ffffff", o_min, o_max); end
        checks++; if (dout !== '0) begin failures++; $display("FAIL mid_dout got=%h want=0", dout); end
        checks++; if (o_stale !== 1'b0) begin failures++; $display("FAIL mid_stale got=%b want=0", o_stale); end
        reset = 1'b0;
        tick();
        frame_start(st);
        checks++; if (st != 0) begin failures++; $display("FAIL mid_stale_g got=%0d want=0", st); end
        checks++; if (o_min !== '0 || o_max !== {3{8'hFF}}) begin failures++; $display("FAIL mid_coef_g min=%h max=%h want 0/ffffff", o_min, o_max); end
        for (int i = 0; i < 3; i++) begin
            drive({3{p[i]}});
            checks++; if (dout !== {3{p[i]}}) begin failures++; $display("FAIL mid_ident pix=%0d got=%h want=%h", p[i], dout, {3{p[i]}}); end
        end
        frame_end(80);
        frame_start(st);
        checks++; if (st != 0) begin failures++; $display("FAIL mid_stale_h got=%0d want=0", st); end
        checks++; if (o_min !== {3{8'd50}} || o_max !== {3{8'd150}}) begin failures++; $display("FAIL mid_coef_h min=%h max=%h want 323232/969696", o_min, o_max); end
        drive({3{8'd100}});
        checks++; if (dout !== {3{8'd127}}) begin failures++; $display("FAIL mid_map got=%h want=7f7f7f", dout); end
    endtask

    task automatic test_bypass();
        logic [7:0] hs_p = 8'b10110010;
        logic [7:0] vs_p = 8'b11100111;
        logic [7:0] de_p = 8'b01101101;
        logic [2:0] want_s;
        logic [W-1:0] want_d;
        en = 1'b0;
        tick();
        checks++; if (dout !== {3{8'd127}}) begin failures++; $display("FAIL byp_t1 got=%h want=7f7f7f", dout); end
        tick();
        checks++; if (dout !== {3{8'd127}}) begin failures++; $display("FAIL byp_t2 got=%h want=7f7f7f", dout); end
        tick();
        checks++; if (dout !== {3{8'd100}}) begin failures++; $display("FAIL byp_t3 got=%h want=646464", dout); end
        din = {3{8'd100}};
        for (int i = 0; i < 8; i++) begin
            i_hsync = hs_p[i]; i_vsync = vs_p[i]; i_de = de_p[i];
            tick();
            if (i >= 2) begin
                want_s = {hs_p[i-2], vs_p[i-2], de_p[i-2]};
                want_d = de_p[i-2] ? {3{8'd100}} : '0;
                checks++; if ({o_hsync, o_vsync, o_de} !== want_s) begin failures++; $display("FAIL sync_delay i=%0d got=%b want=%b", i, {o_hsync, o_vsync, o_de}, want_s); end
                checks++; if (dout !== want_d) begin failures++; $display("FAIL byp_de i=%0d got=%h want=%h", i, dout, want_d); end
            end
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_stretch();
        test_flat();
        test_stale();
        test_reset_mid_div();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

endmodule
